stopwatch_bcd: RTL

//   Consumes the 10 ms tick from the timebase divider; keeps a BCD stopwatch
//   MM:SS.hh (hundredths). Start/stop, lap-freeze and clear come in as
//   one-cycle pulses from the debounced button logic. Output digits drive the

---
 rtl/stopwatch_bcd.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/stopwatch_bcd.sv
// MM:SS.hh BCD stopwatch advanced by a 10 ms tick, with run/pause, lap-freeze
// of the display and clear-from-pause.
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | counters zeroed, waiting for start
// RUN   | counting, display follows live count
// LAP   | counting, display frozen on lap snapshot
// PAUSE | count held; clear returns to IDLE
module stopwatch_bcd #(
    parameter int MIN_MODULUS = 60
) (
    input  logic        clock_in,
    input  logic        reset,
    input  logic        tick,
    input  logic        start_stop,
    input  logic        lap,
    input  logic        clear,
    output logic [23:0] disp,
    output logic        running,
    output logic        lapped,
    output logic        wrap
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_LAP   = 2'd3
    } state_t;

    localparam logic [3:0] MT_LAST = 4'((MIN_MODULUS - 1) / 10);
    localparam logic [3:0] MO_LAST = 4'((MIN_MODULUS - 1) % 10);

    state_t      state_q, state_d;
    logic [23:0] cnt_q, cnt_d;
    logic [23:0] snap_q, snap_d;
    logic [23:0] disp_q, disp_d;
    logic        wrap_q, wrap_d;

    logic [23:0] inc_cnt;
    logic        inc_wrap;
    logic [3:0]  mt, mo, st, so, ht, ho;

    // Live count plus one hundredth, rippling carries up through the minutes.
    always_comb begin
        {mt, mo, st, so, ht, ho} = cnt_q;
        inc_wrap = 1'b0;
        if (ho != 4'd9) begin
            ho = ho + 4'd1;
        end else begin
            ho = 4'd0;
            if (ht != 4'd9) begin
                ht = ht + 4'd1;
            end else begin
                ht = 4'd0;
                if (so != 4'd9) begin
                    so = so + 4'd1;
                end else begin
                    so = 4'd0;
                    if (st != 4'd5) begin
                        st = st + 4'd1;
                    end else begin
                        st = 4'd0;
                        if (mt == MT_LAST && mo == MO_LAST) begin
                            mt       = 4'd0;
                            mo       = 4'd0;
                            inc_wrap = 1'b1;
                        end else if (mo != 4'd9) begin
                            mo = mo + 4'd1;
                        end else begin
                            mo = 4'd0;
                            mt = mt + 4'd1;
                        end
                    end
                end
            end
        end
        inc_cnt = {mt, mo, st, so, ht, ho};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        snap_d  = snap_q;
        wrap_d  = 1'b0;

        // A tick is counted even when the same edge leaves RUN/LAP.
        if (tick && (state_q == S_RUN || state_q == S_LAP)) begin
            cnt_d  = inc_cnt;
            wrap_d = inc_wrap;
        end

        case (state_q)
            S_IDLE: begin
                if (start_stop) state_d = S_RUN;
            end
            S_RUN: begin
                if (start_stop) begin
                    state_d = S_PAUSE;
                end else if (lap) begin
                    state_d = S_LAP;
                    snap_d  = cnt_d;
                end
            end
            S_LAP: begin
                if (start_stop)  state_d = S_PAUSE;
                else if (lap)    state_d = S_RUN;
            end
            S_PAUSE: begin
                if (clear) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (start_stop) begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_IDLE;
        endcase

        disp_d = (state_q == S_LAP) ? snap_q : cnt_q;
    end

    always_ff @(posedge clock_in or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            snap_q  <= '0;
            disp_q  <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            snap_q  <= snap_d;
            disp_q  <= disp_d;
            wrap_q  <= wrap_d;
        end
    end

    assign disp    = disp_q;
    assign wrap    = wrap_q;
    assign running = (state_q == S_RUN) || (state_q == S_LAP);
    assign lapped  = (state_q == S_LAP);

endmodule
